uart_rx: RTL and testbench
==========================

UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 87, meaning i_Clock cycles per UART bit period (frequency of i_Clock / baud rate); legal range 8..65535.
REQ-002 SHALL have port i_Clock  input  1  system clock; all logic runs on its rising edge.
REQ-003 SHALL have port i_Reset  input  1  reset, asynchronous and active-high.
REQ-004 SHALL have port i_Rx_Serial  input  1  asynchronous serial line; idle high.
REQ-005 SHALL have port o_Rx_DV  output  1  one-cycle pulse when o_Rx_Byte holds a newly received, correctly framed byte.
REQ-006 SHALL have port o_Rx_Byte  output  8  last correctly framed byte received.
REQ-007 SHALL have port o_Rx_Active  output  1  high while a frame is being received.
REQ-008 SHALL have port o_Frame_Err  output  1  one-cycle pulse when the stop bit samples low.
REQ-009 SHALL have port o_SM_Main  output  3  current state encoding, for debug.

Function
REQ-010 SHALL pass i_Rx_Serial through a 2-flop synchronizer; the FSM sees only the synchronized value (rx_s), and both flops reset to 1.
REQ-011 SHALL use frame format 8N1: one start bit (0), 8 data bits LSB first, one stop bit (1), no parity.
REQ-012 SHALL implement states IDLE=3'd0, START=3'd1, DATA=3'd2, STOP=3'd3, CLEANUP=3'd4, driven on o_SM_Main; encodings 5..7 SHALL return to IDLE on the next cycle.
REQ-013 IDLE: clock counter held at 0; rx_s=0 -> START.
REQ-014 START: count to (CLKS_PER_BIT-1)/2 (integer division); at terminal count, rx_s=0 -> DATA with counter and bit index cleared; rx_s=1 -> IDLE (glitch rejected, no output pulse).
REQ-015 DATA: count 0..CLKS_PER_BIT-1; at terminal count, shift rx_s into the bit[index] position of an internal shift register and increment index; after index 7 is sampled -> STOP.
REQ-016 STOP: count 0..CLKS_PER_BIT-1; at terminal count, rx_s=1 -> copy the shift register to o_Rx_Byte and pulse o_Rx_DV for exactly one cycle; rx_s=0 -> pulse o_Frame_Err for exactly one cycle and leave o_Rx_Byte unchanged; in either case -> CLEANUP.
REQ-017 CLEANUP: remain until rx_s=1, then -> IDLE; a held-low (break) line therefore produces one o_Frame_Err, not repeated frames.
REQ-018 o_Rx_DV and o_Frame_Err SHALL never be high in the same cycle.
REQ-019 o_Rx_Active SHALL be high exactly when the state is START, DATA or STOP.
REQ-020 The counter SHALL be $clog2(CLKS_PER_BIT) bits wide and never wrap; the bit index SHALL be 3 bits.
REQ-021 Back-to-back frames (stop bit immediately followed by a start bit) SHALL be received without loss; with a line already high, CLEANUP lasts 1 cycle.
REQ-022 Latency: o_Rx_DV rises 2 + ((CLKS_PER_BIT-1)/2 + 1) + 9*CLKS_PER_BIT + 1 cycles (±1) after the first clock edge that samples the start-bit falling edge.

Reset
REQ-023 While i_Reset=1, all of the following SHALL hold, independent of clock: state=IDLE, o_SM_Main=0, o_Rx_DV=0, o_Frame_Err=0, o_Rx_Active=0, o_Rx_Byte=8'h00, counters=0, synchronizer flops=1.
REQ-024 Reset asserted mid-frame SHALL abort the frame without any DV or error pulse; after release, reception SHALL restart only on a new falling edge.

Verification (CLKS_PER_BIT=87, 10 ns clock)
REQ-025 Drive 8'h61 as 8N1 at 87 clocks/bit -> exactly one o_Rx_DV pulse, o_Rx_Byte=8'h61, o_Frame_Err never high, o_Rx_Active low afterwards.
REQ-026 Drive 8'h00, 8'hFF and 8'hA5 back-to-back with no idle gap -> three DV pulses carrying 00, FF and A5 in order.
REQ-027 Drive a 20-cycle low glitch on an idle line -> state returns to IDLE from START; no DV and no error pulse.
REQ-028 Send 8'h3C with stop bit=0, then hold the line low for 2000 cycles -> one o_Frame_Err pulse, o_Rx_Byte keeps its previous value, state stays CLEANUP until the line goes high; a following 8'h55 frame is received correctly.
REQ-029 Assert i_Reset during data bit 4 of a frame -> all outputs return to reset values immediately; a following 8'hC3 frame is received correctly.
REQ-030 Loop the serial output of uart_tx (CLKS_PER_BIT=87) into uart_rx and send 16 random bytes -> all bytes are received in order, and each o_Rx_DV falls within the REQ-022 latency window.

Source files
------------

// File: rtl/uart_rx.sv
// uart_rx: 8N1 asynchronous serial receiver.
// The serial input is double-flopped into rx_s; a single FSM measures bit
// periods with an up-counter, samples each bit at its centre, checks the
// stop bit and reports either a received byte or a framing error.
//
// Ports:
//   i_Clock      system clock, rising edge
//   i_Reset      asynchronous active-high reset
//   i_Rx_Serial  serial line, idle high
//   o_Rx_DV      one-cycle pulse: o_Rx_Byte holds a new, correctly framed byte
//   o_Rx_Byte    last correctly framed byte
//   o_Rx_Active  high in START, DATA and STOP
//   o_Frame_Err  one-cycle pulse: stop bit sampled low
//   o_SM_Main    current state encoding (debug)
//
// State table:
//   IDLE    | line idle, waiting for a falling edge
//   START   | counting to the middle of the start bit
//   DATA    | sampling 8 data bits LSB first, one per bit period
//   STOP    | sampling the stop bit
//   CLEANUP | waiting for the line to return high before re-arming
module uart_rx #(
  parameter int CLKS_PER_BIT = 87
) (
  input  logic       i_Clock,
  input  logic       i_Reset,
  input  logic       i_Rx_Serial,
  output logic       o_Rx_DV,
  output logic [7:0] o_Rx_Byte,
  output logic       o_Rx_Active,
  output logic       o_Frame_Err,
  output logic [2:0] o_SM_Main
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_CNT = CW'((CLKS_PER_BIT - 1) / 2);
  localparam logic [CW-1:0] LAST_CNT = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    START   = 3'd1,
    DATA    = 3'd2,
    STOP    = 3'd3,
    CLEANUP = 3'd4
  } state_t;

  state_t        state;
  logic [CW-1:0] clk_cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shift;
  logic          rx_meta;
  logic          rx_s;

  // Synchronizer resets high so a reset never looks like a start bit.
  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= i_Rx_Serial;
      rx_s    <= rx_meta;
    end
  end

  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      state       <= IDLE;
      clk_cnt     <= '0;
      bit_idx     <= '0;
      shift       <= '0;
      o_Rx_Byte   <= '0;
      o_Rx_DV     <= 1'b0;
      o_Frame_Err <= 1'b0;
    end else begin
      o_Rx_DV     <= 1'b0;
      o_Frame_Err <= 1'b0;
      case (state)
        IDLE: begin
          clk_cnt <= '0;
          bit_idx <= '0;
          if (!rx_s) state <= START;
        end
        START: begin
          if (clk_cnt == HALF_CNT) begin
            clk_cnt <= '0;
            bit_idx <= '0;
            // Line back high at mid start bit: treat as a glitch.
            state   <= rx_s ? IDLE : DATA;
          end else begin
            clk_cnt <= clk_cnt + CW'(1);
          end
        end
        DATA: begin
          if (clk_cnt == LAST_CNT) begin
            clk_cnt         <= '0;
            shift[bit_idx]  <= rx_s;
            bit_idx         <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) state <= STOP;
          end else begin
            clk_cnt <= clk_cnt + CW'(1);
          end
        end
        STOP: begin
          if (clk_cnt == LAST_CNT) begin
            clk_cnt <= '0;
            if (rx_s) begin
              o_Rx_Byte <= shift;
              o_Rx_DV   <= 1'b1;
            end else begin
              o_Frame_Err <= 1'b1;
            end
            state <= CLEANUP;
          end else begin
            clk_cnt <= clk_cnt + CW'(1);
          end
        end
        CLEANUP: begin
          clk_cnt <= '0;
          // A held-low break line parks here instead of re-triggering.
          if (rx_s) state <= IDLE;
        end
        default: begin
          clk_cnt <= '0;
          state   <= IDLE;
        end
      endcase
    end
  end

  assign o_Rx_Active = (state == START) || (state == DATA) || (state == STOP);
  assign o_SM_Main   = state;

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed bench for uart_rx at 87 clocks/bit, 10 ns clock.
// A behavioural serial driver produces frames; a monitor records every
// DV pulse (byte and cycle), framing-error pulses and any cycle where both
// pulses are high. Expected bytes and latencies are fixed by the bench.
module tb_uart_rx;

  localparam int CPB = 87;
  // start seen at edge E0 -> rx_s at E1 -> START at E2 -> DATA after 44
  // counts -> 8 data + stop periods of 87 -> DV visible after E829,
  // i.e. 830 cycles after the negedge that drove the start bit.
  localparam int LAT_NOM = 830;

  logic       clk;
  logic       rst;
  logic       rx;
  logic       dv;
  logic [7:0] rx_byte;
  logic       active;
  logic       ferr;
  logic [2:0] sm;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int fe_cnt = 0;
  int both_cnt = 0;
  logic [7:0] dv_q[$];
  int         dv_cyc[$];
  logic [7:0] exp_q[$];
  int         start_cyc[$];

  uart_rx #(.CLKS_PER_BIT(CPB)) dut (
    .i_Clock    (clk),
    .i_Reset    (rst),
    .i_Rx_Serial(rx),
    .o_Rx_DV    (dv),
    .o_Rx_Byte  (rx_byte),
    .o_Rx_Active(active),
    .o_Frame_Err(ferr),
    .o_SM_Main  (sm)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (dv) begin
      dv_q.push_back(rx_byte);
      dv_cyc.push_back(cyc);
    end
    if (ferr) fe_cnt <= fe_cnt + 1;
    if (dv && ferr) both_cnt <= both_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Called on a negedge; returns on the negedge ending the stop bit.
  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    rx = 1'b0;
    if (stop_bit) begin
      exp_q.push_back(b);
      start_cyc.push_back(cyc);
    end
    wait_clks(CPB);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      wait_clks(CPB);
    end
    rx = stop_bit;
    wait_clks(CPB);
  endtask

  initial begin
    int n0;
    int lat;
    logic [7:0] rb;

    rst = 1'b1;
    rx  = 1'b1;
    #1;
    chk("rst_state", 32'(sm), 32'd0);
    chk("rst_dv", 32'(dv), 32'd0);
    chk("rst_ferr", 32'(ferr), 32'd0);
    chk("rst_active", 32'(active), 32'd0);
    chk("rst_byte", 32'(rx_byte), 32'h00);
    wait_clks(5);
    rst = 1'b0;
    wait_clks(5);
    chk("idle_state", 32'(sm), 32'd0);

    // single byte
    send_frame(8'h61, 1'b1);
    wait_clks(10);
    chk("b61_count", 32'(dv_q.size()), 32'd1);
    if (dv_q.size() >= 1) chk("b61_byte", 32'(dv_q[0]), 32'h61);
    chk("b61_ferr", 32'(fe_cnt), 32'd0);
    chk("b61_active", 32'(active), 32'd0);
    chk("b61_hold", 32'(rx_byte), 32'h61);

    // back-to-back, no idle gap
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    send_frame(8'hA5, 1'b1);
    wait_clks(10);
    chk("b2b_count", 32'(dv_q.size()), 32'd4);
    if (dv_q.size() >= 4) begin
      chk("b2b_0", 32'(dv_q[1]), 32'h00);
      chk("b2b_1", 32'(dv_q[2]), 32'hFF);
      chk("b2b_2", 32'(dv_q[3]), 32'hA5);
    end

    // 20-cycle glitch
    n0 = dv_q.size();
    rx = 1'b0;
    wait_clks(10);
    chk("glitch_in_start", 32'(sm), 32'd1);
    wait_clks(10);
    rx = 1'b1;
    wait_clks(100);
    chk("glitch_idle", 32'(sm), 32'd0);
    chk("glitch_no_dv", 32'(dv_q.size()), 32'(n0));
    chk("glitch_no_ferr", 32'(fe_cnt), 32'd0);

    // framing error followed by a break
    send_frame(8'h3C, 1'b0);
    wait_clks(2000);
    chk("ferr_count", 32'(fe_cnt), 32'd1);
    chk("ferr_byte_kept", 32'(rx_byte), 32'hA5);
    chk("ferr_cleanup", 32'(sm), 32'd4);
    chk("ferr_no_dv", 32'(dv_q.size()), 32'(n0));
    rx = 1'b1;
    wait_clks(10);
    chk("ferr_back_idle", 32'(sm), 32'd0);
    send_frame(8'h55, 1'b1);
    wait_clks(10);
    chk("b55_count", 32'(dv_q.size()), 32'(n0 + 1));
    chk("b55_byte", 32'(rx_byte), 32'h55);

    // reset during data bit 4
    n0 = dv_q.size();
    rx = 1'b0;
    wait_clks(CPB);
    for (int i = 0; i < 4; i++) begin
      rx = i[0];
      wait_clks(CPB);
    end
    rx = 1'b1;
    wait_clks(40);
    chk("abort_active_before", 32'(active), 32'd1);
    rst = 1'b1;
    #1;
    chk("abort_state", 32'(sm), 32'd0);
    chk("abort_active", 32'(active), 32'd0);
    chk("abort_byte", 32'(rx_byte), 32'h00);
    chk("abort_dv", 32'(dv), 32'd0);
    wait_clks(5);
    rst = 1'b0;
    wait_clks(600);
    chk("abort_stays_idle", 32'(sm), 32'd0);
    chk("abort_no_dv", 32'(dv_q.size()), 32'(n0));
    chk("abort_no_ferr", 32'(fe_cnt), 32'd1);
    send_frame(8'hC3, 1'b1);
    wait_clks(10);
    chk("bC3_byte", 32'(rx_byte), 32'hC3);

    // 16 random bytes, back-to-back
    for (int i = 0; i < 16; i++) begin
      rb = 8'($urandom_range(0, 255));
      send_frame(rb, 1'b1);
    end
    wait_clks(20);

    chk("total_count", 32'(dv_q.size()), 32'(exp_q.size()));
    if (dv_q.size() == exp_q.size()) begin
      for (int i = 0; i < exp_q.size(); i++) begin
        chk($sformatf("byte_%0d", i), 32'(dv_q[i]), 32'(exp_q[i]));
        lat = dv_cyc[i] - start_cyc[i];
        chk($sformatf("lat_%0d_d%0d", i, lat),
            32'((lat >= LAT_NOM - 1) && (lat <= LAT_NOM + 1)), 32'd1);
      end
    end
    chk("final_ferr", 32'(fe_cnt), 32'd1);
    chk("dv_ferr_overlap", 32'(both_cnt), 32'd0);
    chk("final_active", 32'(active), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
